// File: rtl/dft_pkg.sv
// dft_pkg: shared types and constants for the DFT frame sequencer.
// Holds the sequencer state enum, default word width and frame length.
package dft_pkg;

  localparam int WORD_SZ_DEF = 16;
  localparam int FRAME_LEN   = 4;
  localparam int IDX_W       = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CALC   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/dft_frame_sequencer.sv
// dft_frame_sequencer: 4-sample load/calc/unload sequencer for an external DFT network.
// Define DFT_SEQ_BITREV_EN to load operands into slots in bit-reversed order.
module dft_frame_sequencer
  import dft_pkg::*;
#(
  parameter int WORD_SZ = WORD_SZ_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WORD_SZ-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORD_SZ-1:0] o_data,
  output logic               o_last,
  output logic [WORD_SZ-1:0] o_net_A,
  output logic [WORD_SZ-1:0] o_net_B,
  output logic [WORD_SZ-1:0] o_net_C,
  output logic [WORD_SZ-1:0] o_net_D,
  input  logic [WORD_SZ-1:0] i_net_A,
  input  logic [WORD_SZ-1:0] i_net_B,
  input  logic [WORD_SZ-1:0] i_net_C,
  input  logic [WORD_SZ-1:0] i_net_D,
  output logic               o_busy
);

  state_t r_state;
  state_t w_nxt;

  logic [IDX_W-1:0]   r_ld_idx;
  logic [IDX_W-1:0]   r_ul_idx;
  logic [IDX_W-1:0]   w_slot;
  logic [WORD_SZ-1:0] r_op  [FRAME_LEN];
  logic [WORD_SZ-1:0] r_res [FRAME_LEN];
  logic [15:0]        r_frame_cnt;

  logic w_in_hs;
  logic w_out_hs;
  logic w_last;

  assign o_ready  = (r_state == ST_LOAD);
  assign o_valid  = (r_state == ST_UNLOAD);
  assign w_last   = (r_ul_idx == LAST_IDX);
  assign o_last   = o_valid && w_last;
  assign o_data   = r_res[r_ul_idx];
  assign o_busy   = (r_state != ST_LOAD) || (r_ld_idx != '0);
  assign w_in_hs  = i_valid && o_ready;
  assign w_out_hs = o_valid && i_ready;

  assign o_net_A = r_op[0];
  assign o_net_B = r_op[1];
  assign o_net_C = r_op[2];
  assign o_net_D = r_op[3];

`ifdef DFT_SEQ_BITREV_EN
  assign w_slot = {r_ld_idx[0], r_ld_idx[1]};
`else
  assign w_slot = r_ld_idx;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_LOAD: begin
        if (w_in_hs && (r_ld_idx == LAST_IDX)) w_nxt = ST_CALC;
      end
      ST_CALC: begin
        w_nxt = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (w_out_hs && w_last) w_nxt = ST_LOAD;
      end
      default: begin
        w_nxt = ST_LOAD;
      end
    endcase
    // Abort beats any handshake in the same cycle
    if (i_flush) w_nxt = ST_LOAD;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_idx    <= '0;
      r_ul_idx    <= '0;
      r_frame_cnt <= '0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_op[i]  <= '0;
        r_res[i] <= '0;
      end
    end else if (i_flush) begin
      r_ld_idx <= '0;
      r_ul_idx <= '0;
    end else begin
      if (w_in_hs) begin
        r_op[w_slot] <= i_data;
        r_ld_idx     <= r_ld_idx + 2'd1;
      end
      if (r_state == ST_CALC) begin
        r_res[0] <= i_net_A;
        r_res[1] <= i_net_B;
        r_res[2] <= i_net_C;
        r_res[3] <= i_net_D;
      end
      if (w_out_hs) begin
        r_ul_idx <= r_ul_idx + 2'd1;
        if (w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// tb_dft_frame_sequencer: directed bench with a queue-based frame model and a DFT network model.
// Honours DFT_SEQ_BITREV_EN for the network wiring and operand slot expectations.
module tb_dft_frame_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] o_data;
  logic        o_last;
  logic [15:0] o_net_A, o_net_B, o_net_C, o_net_D;
  logic [15:0] i_net_A, i_net_B, i_net_C, i_net_D;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  dft_frame_sequencer #(.WORD_SZ(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_net_A(o_net_A), .o_net_B(o_net_B), .o_net_C(o_net_C), .o_net_D(o_net_D),
    .i_net_A(i_net_A), .i_net_B(i_net_B), .i_net_C(i_net_C), .i_net_D(i_net_D),
    .o_busy(o_busy)
  );

  // Unscaled 4-point DFT of x0..x3 in natural order, 8-bit wrapping halves
  function automatic logic [15:0] dft_bin(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d,
                                          input int k);
    int ar, ai, br, bi, cr, ci, dr, di, re, im;
    ar = int'($signed(a[15:8])); ai = int'($signed(a[7:0]));
    br = int'($signed(b[15:8])); bi = int'($signed(b[7:0]));
    cr = int'($signed(c[15:8])); ci = int'($signed(c[7:0]));
    dr = int'($signed(d[15:8])); di = int'($signed(d[7:0]));
    case (k)
      0: begin re = ar + br + cr + dr; im = ai + bi + ci + di; end
      1: begin re = ar + bi - cr - di; im = ai - br - ci + dr; end
      2: begin re = ar - br + cr - dr; im = ai - bi + ci - di; end
      default: begin re = ar - bi - cr + di; im = ai + br - ci - dr; end
    endcase
    return {re[7:0], im[7:0]};
  endfunction

`ifdef DFT_SEQ_BITREV_EN
  assign i_net_A = dft_bin(o_net_A, o_net_C, o_net_B, o_net_D, 0);
  assign i_net_B = dft_bin(o_net_A, o_net_C, o_net_B, o_net_D, 1);
  assign i_net_C = dft_bin(o_net_A, o_net_C, o_net_B, o_net_D, 2);
  assign i_net_D = dft_bin(o_net_A, o_net_C, o_net_B, o_net_D, 3);
`else
  assign i_net_A = dft_bin(o_net_A, o_net_B, o_net_C, o_net_D, 0);
  assign i_net_B = dft_bin(o_net_A, o_net_B, o_net_C, o_net_D, 1);
  assign i_net_C = dft_bin(o_net_A, o_net_B, o_net_C, o_net_D, 2);
  assign i_net_D = dft_bin(o_net_A, o_net_B, o_net_C, o_net_D, 3);
`endif

  // Frame model: collected samples, one-cycle compute gap, pending bins
  logic [15:0] m_smp[$];
  logic [15:0] m_bins[$];
  logic [15:0] m_frm[4];
  logic [15:0] m_slot[4];
  bit          m_gap;
  int          m_fcnt;

  function automatic int slot_of(input int n);
`ifdef DFT_SEQ_BITREV_EN
    return ((n & 1) << 1) | ((n >> 1) & 1);
`else
    return n;
`endif
  endfunction

  task automatic model_reset();
    m_smp.delete();
    m_bins.delete();
    m_gap = 0;
    m_fcnt = 0;
    for (int i = 0; i < 4; i++) m_slot[i] = '0;
  endtask

  task automatic model_edge();
    if (!i_rst_n) begin
      model_reset();
    end else if (i_flush) begin
      m_smp.delete();
      m_bins.delete();
      m_gap = 0;
    end else if (m_gap) begin
      for (int k = 0; k < 4; k++)
        m_bins.push_back(dft_bin(m_frm[0], m_frm[1], m_frm[2], m_frm[3], k));
      m_gap = 0;
    end else if (m_bins.size() > 0) begin
      if (i_ready) begin
        if (m_bins.size() == 1) m_fcnt = (m_fcnt + 1) % 65536;
        void'(m_bins.pop_front());
      end
    end else if (i_valid) begin
      m_slot[slot_of(m_smp.size())] = i_data;
      m_smp.push_back(i_data);
      if (m_smp.size() == 4) begin
        for (int i = 0; i < 4; i++) m_frm[i] = m_smp[i];
        m_smp.delete();
        m_gap = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit ev, er;
    er = !m_gap && (m_bins.size() == 0);
    ev = (m_bins.size() > 0);
    chk("ready", 32'(o_ready), 32'(er));
    chk("valid", 32'(o_valid), 32'(ev));
    chk("last", 32'(o_last), 32'(ev && m_bins.size() == 1));
    chk("busy", 32'(o_busy), 32'(!(er && m_smp.size() == 0)));
    if (ev) chk("data", 32'(o_data), 32'(m_bins[0]));
    chk("net_A", 32'(o_net_A), 32'(m_slot[0]));
    chk("net_B", 32'(o_net_B), 32'(m_slot[1]));
    chk("net_C", 32'(o_net_C), 32'(m_slot[2]));
    chk("net_D", 32'(o_net_D), 32'(m_slot[3]));
    chk("frame_cnt", 32'(dut.r_frame_cnt), 32'(m_fcnt));
  endtask

  task automatic cycle();
    @(negedge i_clk);
    compare();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic beat(input logic [15:0] d);
    i_valid = 1'b1;
    i_data = d;
    cycle();
    i_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    beat(a); beat(b); beat(c); beat(d);
  endtask

  task automatic take(output logic [15:0] d, output logic l);
    int n;
    n = 0;
    i_ready = 1'b1;
    while (!o_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("take_wait", 32'(o_valid), 32'd1);
    d = o_data;
    l = o_last;
    cycle();
  endtask

  task automatic take4(input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] e2, input logic [15:0] e3, input string nm);
    logic [15:0] d;
    logic        l;
    logic [15:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < 4; k++) begin
      take(d, l);
      chk({nm, "_bin"}, 32'(d), 32'(e[k]));
      chk({nm, "_lastflag"}, 32'(l), 32'(k == 3));
    end
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_nets", 32'({o_net_A, o_net_B} | {o_net_C, o_net_D}), 32'd0);
    model_reset();
    cycle();
    cycle();
    i_rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        l;
    logic [15:0] hold;
    model_reset();
    pulse_reset();

    // Impulse -> flat spectrum, first frame count
    frame(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    take4(16'h0100, 16'h0100, 16'h0100, 16'h0100, "impulse");
    chk("fcnt_one", 32'(dut.r_frame_cnt), 32'd1);

    // Constant input with latency pinned
    frame(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    chk("lat_calc_valid", 32'(o_valid), 32'd0);
    chk("lat_calc_ready", 32'(o_ready), 32'd0);
    i_ready = 1'b1;
    cycle();
    chk("lat_valid", 32'(o_valid), 32'd1);
    chk("lat_bin0", 32'(o_data), 32'h0400);
    take4(16'h0400, 16'h0000, 16'h0000, 16'h0000, "const");
    chk("fcnt_two", 32'(dut.r_frame_cnt), 32'd2);

    // Ramp, slot order, and a 5-cycle stall
    frame(16'h0100, 16'h0200, 16'h0300, 16'h0400);
`ifdef DFT_SEQ_BITREV_EN
    chk("netB_order", 32'(o_net_B), 32'h0300);
`else
    chk("netB_order", 32'(o_net_B), 32'h0200);
`endif
    take(d, l);
    chk("ramp_bin0", 32'(d), 32'h0A00);
    i_ready = 1'b0;
    hold = o_data;
    repeat (5) cycle();
    chk("stall_data", 32'(o_data), 32'(hold));
    chk("stall_bin1", 32'(o_data), 32'hFE02);
    chk("stall_last", 32'(o_last), 32'd0);
    take(d, l); chk("ramp_bin1", 32'(d), 32'hFE02);
    take(d, l); chk("ramp_bin2", 32'(d), 32'hFE00);
    take(d, l); chk("ramp_bin3", 32'(d), 32'hFEFE);
    chk("ramp_last", 32'(l), 32'd1);

    // Flush after two beats, racing a third beat
    beat(16'h1111);
    beat(16'h2222);
    i_flush = 1'b1; i_valid = 1'b1; i_data = 16'h3333;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_busy", 32'(o_busy), 32'd0);
    chk("flush_keep_A", 32'(o_net_A), 32'h1111);
    frame(16'h0102, 16'h0304, 16'hFF01, 16'h8000);
    take(d, l);
    chk("cplx_bin0", 32'(d), 32'h8307);
    repeat (4) cycle();

    // Flush during unload
    frame(16'h0300, 16'h0000, 16'h0000, 16'h0000);
    take(d, l);
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    chk("uflush_valid", 32'(o_valid), 32'd0);
    chk("uflush_ready", 32'(o_ready), 32'd1);

    // Reset mid-load, then mid-unload
    beat(16'h7777);
    beat(16'h6666);
    pulse_reset();
    frame(16'h0500, 16'h0000, 16'h0000, 16'h0000);
    take4(16'h0500, 16'h0500, 16'h0500, 16'h0500, "post_rst");
    frame(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    take(d, l);
    pulse_reset();
    chk("rst_fcnt", 32'(dut.r_frame_cnt), 32'd0);
    frame(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    take4(16'h0004, 16'h0000, 16'h0000, 16'h0000, "post_rst2");

    // Irregular ready pattern across a full frame
    frame(16'h10F0, 16'h2001, 16'hF010, 16'h0203);
    for (int i = 0; i < 14; i++) begin
      i_ready = ((i % 3) != 1);
      cycle();
    end
    i_ready = 1'b1;
    repeat (3) cycle();
    chk("final_idle", 32'(o_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
